inv_mix_columns_seq: RTL
========================

Name: inv_mix_columns_seq

Overview:
Iterative AES-128 InvMixColumns engine for the decryption datapath. It is the inverse of the combinational forward MixColumns block. It accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE 32-bit columns per clock through a shared GF(2^8) multiply unit. It returns the result on a second valid/ready handshake and sits between the inverse-SubBytes/AddRoundKey stages of the round controller.

Parameters:
COLS_PER_CYCLE, 1, number of columns transformed per clock; legal values 1, 2, 4 (other values are an elaboration error).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a new state
in_data  input  128  state to transform
out_valid  output  1  out_data holds a completed result
out_ready  input  1  consumer accepts out_data
out_data  output  128  transformed state
busy  output  1  high in RUN or DONE

Behaviour:
- Column layout: word k = bits [32k+31:32k], k=0..3. Row 0 byte = bits [32k+31:32k+24], row 3 byte = bits [32k+7:32k]. Words are processed from k=3 (bits 127:96) down to k=0.
- Per column (a0..a3 = rows 0..3): b0=0e·a0^0b·a1^0d·a2^09·a3; b1=09·a0^0e·a1^0b·a2^0d·a3; b2=0d·a0^09·a1^0e·a2^0b·a3; b3=0b·a0^0d·a1^09·a2^0e·a3.
- GF(2^8) arithmetic uses polynomial 0x11B. xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0x00). Multiplication by 09/0b/0d/0e is built from xtime chains: x2, x4, x8 and XOR combinations.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the working register, clear the column counter, go to RUN.
  - RUN: each clock, transform COLS_PER_CYCLE columns in place in the working register and advance the counter by COLS_PER_CYCLE. When the last column is written, go to DONE.
  - DONE: out_valid=1 and out_data = working register. out_data must stay stable while out_valid&&!out_ready. On out_ready, go to IDLE.
- Latency: accept edge to out_valid assertion is 4/COLS_PER_CYCLE clocks (4, 2 or 1).
- Throughput: one state per 4/COLS_PER_CYCLE+2 clocks with out_ready tied high.
- in_ready is 0 in RUN and DONE. in_valid asserted then is ignored: no latch, no error.
- in_data is sampled only on the accept edge. Changes afterward have no effect.
- Simultaneous out_ready in DONE and in_valid: the new state is not accepted that cycle (in_ready=0). It is accepted on the next IDLE cycle.
- The column counter wraps only via the RUN to DONE transition. It never exceeds 3.
- Reset values (asynchronous, rst_n low): state=IDLE, in_ready=1 after release, out_valid=0, busy=0, out_data=128'h0, counter=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The pending result is discarded and is never presented.
- out_data bits hold their value in IDLE. Consumers sample them only under out_valid.

Test Plan:
1. Known-answer test, COLS_PER_CYCLE=1: in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_valid exactly 4 clocks after the accept edge, out_data=db135345_f20a225c_01010101_d4d4d4d5.
2. Fixed points: in_data=01010101_c6c6c6c6_01010101_c6c6c6c6 -> out_data equal to in_data. A second vector, 4d7ebdf8 in every word -> 2d26314c in every word.
3. Backpressure: hold out_ready=0 for 10 clocks after out_valid and drive in_valid=1 with random in_data throughout -> out_data stable, in_ready=0, no second accept. Release out_ready -> IDLE next clock, then accept.
4. Parameter sweep: COLS_PER_CYCLE=2 and 4 with vector 1 -> same out_data, latency 2 and 1 clocks respectively.
5. Reset mid-operation: assert rst_n=0 two clocks into RUN -> out_valid=0 and out_data=0 immediately. After release, no stale out_valid appears. A new vector 1 transaction completes correctly.
6. Round trip: 1000 random states through a forward MixColumns model then this block, with random out_ready stalls -> output equals the original state every time, in order, none dropped or duplicated.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine. A 128-bit state is accepted over a
// valid/ready handshake, transformed COLS_PER_CYCLE columns per clock in a
// single working register, and presented on a second valid/ready handshake.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_t       state, state_next;
  logic [127:0] work, work_next;
  logic [1:0]   cnt, cnt_next;
  logic [2:0]   cnt_sum;
  logic [1:0]   idx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = xtime(a);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(a));
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column: row 0 sits in the most significant byte of the word.
  function automatic logic [31:0] inv_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Next-state, handshake outputs and in-place column transform.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    work_next  = work;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    idx        = 2'd0;
    cnt_sum    = {1'b0, cnt} + STEP;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_next  = in_data;
          cnt_next   = 2'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Columns are consumed from word 3 (bits 127:96) downwards.
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          idx = 2'd3 - cnt - 2'(j);
          work_next[{idx, 5'b0} +: 32] = inv_col(work[{idx, 5'b0} +: 32]);
        end
        if (cnt_sum == 3'd4) begin
          cnt_next   = 2'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_sum[1:0];
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and working register; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      work  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      work  <= work_next;
    end
  end

  assign out_data = work;

endmodule
